// File: rtl/sr_drive_pkg.sv
// ============================================================================
// Module : sr_drive_pkg
// Desc   : Shared state encoding and default sizing for the SR latch driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;
    localparam int unsigned DEF_DEAD_CYCLES     = 1;

    localparam int unsigned DROP_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/sr_drive_ctrl_if.sv
// ============================================================================
// Module : sr_drive_ctrl_if
// Desc   : Button inputs and latch-drive/status outputs of the SR driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sr_drive_ctrl_if;
    import sr_drive_pkg::*;

    logic                  set_btn;
    logic                  reset_btn;
    logic                  s;
    logic                  r;
    logic                  busy;
    logic                  q_track;
    logic                  conflict;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output set_btn, reset_btn,
        input  s, r, busy, q_track, conflict, drop_cnt
    );

    modport slave (
        input  set_btn, reset_btn,
        output s, r, busy, q_track, conflict, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Desc   : Synchroniser, stability-count debounce and one-cycle press request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_req
);

    localparam int unsigned c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_req;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_req    = r_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_req     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_level_d <= r_level;
            r_req     <= r_level & ~r_level_d;
            // Any cycle agreeing with the current level restarts the count.
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sr_drive_ctrl.sv
// ============================================================================
// Module : sr_drive_ctrl
// Desc   : Debounced, interlocked fixed-width S/R pulse driver for a NOR latch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned DEAD_CYCLES     = DEF_DEAD_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    sr_drive_ctrl_if.slave bus
);

    localparam int unsigned c_tmr_max = (PULSE_CYCLES > DEAD_CYCLES) ? PULSE_CYCLES : DEAD_CYCLES;
    localparam int unsigned c_tmr_w   = $clog2(c_tmr_max + 1);

    state_t                r_state;
    logic [c_tmr_w-1:0]    r_tmr;
    logic                  r_s;
    logic                  r_r;
    logic                  r_q_track;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_req_set;
    logic                  w_req_rst;
    logic [DROP_CNT_W:0]   w_drop_sum;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_set_db (
        .clk   (clk),
        .rst   (rst),
        .i_btn (bus.set_btn),
        .o_req (w_req_set)
    );

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rst_db (
        .clk   (clk),
        .rst   (rst),
        .i_btn (bus.reset_btn),
        .o_req (w_req_rst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_q_track <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tmr <= '0;
                    // Simultaneous requests are ambiguous, so neither is honoured.
                    if (w_req_set && !w_req_rst) begin
                        r_state <= SET_P;
                        r_s     <= 1'b1;
                    end else if (w_req_rst && !w_req_set) begin
                        r_state <= RST_P;
                        r_r     <= 1'b1;
                    end
                end
                SET_P, RST_P: begin
                    if (r_tmr == c_tmr_w'(PULSE_CYCLES - 1)) begin
                        r_s       <= 1'b0;
                        r_r       <= 1'b0;
                        r_q_track <= (r_state == SET_P);
                        r_tmr     <= '0;
                        r_state   <= (DEAD_CYCLES == 0) ? IDLE : DEAD;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                DEAD: begin
                    if (r_tmr == c_tmr_w'(DEAD_CYCLES - 1)) begin
                        r_tmr   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tmr   <= '0;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                end
            endcase
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt}
                      + (DROP_CNT_W + 1)'(w_req_set)
                      + (DROP_CNT_W + 1)'(w_req_rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (r_state != IDLE) begin
            if (w_drop_sum[DROP_CNT_W]) begin
                r_drop_cnt <= '1;
            end else begin
                r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    assign bus.s        = r_s;
    assign bus.r        = r_r;
    assign bus.busy     = (r_state != IDLE);
    assign bus.q_track  = r_q_track;
    assign bus.conflict = (r_state == IDLE) && w_req_set && w_req_rst;
    assign bus.drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
// ============================================================================
// Module : tb_sr_drive_ctrl
// Desc   : Directed, table-driven self-checking bench for sr_drive_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sr_drive_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   overlap_cnt;

    sr_drive_ctrl_if bus();

    sr_drive_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (2),
        .DEAD_CYCLES     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.s && bus.r) overlap_cnt++;
    end

    // Button windows are half-open [on, off); output windows are closed [on, off].
    typedef struct {
        string name;
        int    set_on,  set_off;
        int    rb_on,   rb_off;
        int    s_on,    s_off;
        int    r_on,    r_off;
        int    busy_on, busy_off;
        int    conf_edge;
        int    q_from;
        int    drop_final;
    } scen_t;

    scen_t scen [7];

    task automatic step(input logic rs, input logic sb, input logic rb);
        rst           = rs;
        bus.set_btn   = sb;
        bus.reset_btn = rb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", nm, k, act, exp);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        overlap_cnt   = 0;
        rst           = 1'b1;
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;

        scen[0] = '{"clean_set",      0, 40, 0,  0,  7,  8, -1, -2,  7,  9, -1,  9, 0};
        scen[1] = '{"clean_reset",    0,  0, 0, 40, -1, -2,  7,  8,  7,  9, -1, -1, 0};
        scen[2] = '{"same_edge",      0, 40, 0, 40, -1, -2, -1, -2, -1, -2,  6, -1, 0};
        scen[3] = '{"reset_in_pulse", 0, 40, 1, 40,  7,  8, -1, -2,  7,  9, -1,  9, 1};
        scen[4] = '{"min_press",      0,  4, 0,  0,  7,  8, -1, -2,  7,  9, -1,  9, 0};
        scen[5] = '{"short_glitch",   0,  3, 0,  0, -1, -2, -1, -2, -1, -2, -1, -1, 0};
        scen[6] = '{"reset_in_dead",  0, 40, 3, 40,  7,  8, -1, -2,  7,  9, -1,  9, 1};

        // Reset state, with both buttons held high during reset.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_s",        0, int'(bus.s),        0);
        chk("rst_r",        0, int'(bus.r),        0);
        chk("rst_busy",     0, int'(bus.busy),     0);
        chk("rst_q_track",  0, int'(bus.q_track),  0);
        chk("rst_conflict", 0, int'(bus.conflict), 0);
        chk("rst_drop_cnt", 0, int'(bus.drop_cnt), 0);

        for (int n = 0; n < 7; n++) begin
            do_reset();
            for (int k = 0; k < 20; k++) begin
                step(1'b0,
                     (k >= scen[n].set_on) && (k < scen[n].set_off),
                     (k >= scen[n].rb_on)  && (k < scen[n].rb_off));
                chk({scen[n].name, ".s"},        k, int'(bus.s),
                    int'((k >= scen[n].s_on) && (k <= scen[n].s_off)));
                chk({scen[n].name, ".r"},        k, int'(bus.r),
                    int'((k >= scen[n].r_on) && (k <= scen[n].r_off)));
                chk({scen[n].name, ".busy"},     k, int'(bus.busy),
                    int'((k >= scen[n].busy_on) && (k <= scen[n].busy_off)));
                chk({scen[n].name, ".conflict"}, k, int'(bus.conflict),
                    int'(k == scen[n].conf_edge));
                chk({scen[n].name, ".q_track"},  k, int'(bus.q_track),
                    int'((scen[n].q_from >= 0) && (k >= scen[n].q_from)));
            end
            chk({scen[n].name, ".drop_cnt"}, 19, int'(bus.drop_cnt), scen[n].drop_final);
        end

        // Bouncing set button: toggles every cycle, never stable long enough.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            step(1'b0, (k < 12) && (k % 2 == 0), 1'b0);
            chk("bounce.s",       k, int'(bus.s),       0);
            chk("bounce.r",       k, int'(bus.r),       0);
            chk("bounce.busy",    k, int'(bus.busy),    0);
            chk("bounce.q_track", k, int'(bus.q_track), 0);
        end
        chk("bounce.drop_cnt", 29, int'(bus.drop_cnt), 0);

        // Reset mid-pulse with the set button still held.
        do_reset();
        for (int k = 0; k < 26; k++) begin
            step(k == 8, 1'b1, 1'b0);
            chk("midrst.s",       k, int'(bus.s),
                int'((k == 7) || ((k >= 16) && (k <= 17))));
            chk("midrst.busy",    k, int'(bus.busy),
                int'((k == 7) || ((k >= 16) && (k <= 18))));
            chk("midrst.q_track", k, int'(bus.q_track), int'(k >= 18));
        end

        // Set press, then a reset press well after the dead time.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b0, k < 4, (k >= 24) && (k < 30));
            chk("seq.s",       k, int'(bus.s),       int'((k >= 7) && (k <= 8)));
            chk("seq.r",       k, int'(bus.r),       int'((k >= 31) && (k <= 32)));
            chk("seq.q_track", k, int'(bus.q_track), int'((k >= 9) && (k < 33)));
        end
        chk("seq.drop_cnt", 39, int'(bus.drop_cnt), 0);

        chk("no_overlap", 0, overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
